// File: rtl/mc_controller_pkg.sv
// mc_defs: shared encodings for the multi-cycle MIPS-subset controller.
// Latency: n/a (constants, types and one helper only).
// Backpressure: n/a.
package mc_defs;

   // FSM state encodings (also exported on the debug state port)
   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM_RD = 3'd3,
      ST_MEM_WR = 3'd4,
      ST_WB     = 3'd5,
      ST_BRANCH = 3'd6,
      ST_JUMP   = 3'd7
   } state_t;

   // opcode field IR[31:26]
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   // func field IR[5:0] for R-type
   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_JR    = 6'b001000;

   // next-PC select
   localparam logic [1:0] PC_SEQ    = 2'b00;  // PC+4
   localparam logic [1:0] PC_BRANCH = 2'b01;  // PC+(sext(imm)<<2)
   localparam logic [1:0] PC_JUMP   = 2'b10;  // {PC[31:28],idx,00}
   localparam logic [1:0] PC_GPR    = 2'b11;  // GPR[rs]

   // register destination select
   localparam logic [1:0] RD_RT = 2'b00;
   localparam logic [1:0] RD_RD = 2'b01;
   localparam logic [1:0] RD_RA = 2'b10;      // $31

   // write-data select
   localparam logic [1:0] WD_ALU = 2'b00;
   localparam logic [1:0] WD_MDR = 2'b01;
   localparam logic [1:0] WD_PC  = 2'b10;

   // immediate extension
   localparam logic [1:0] EXT_ZERO = 2'b00;
   localparam logic [1:0] EXT_SIGN = 2'b01;
   localparam logic [1:0] EXT_HI   = 2'b10;

   // ALU operation
   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_OR  = 4'b0010;

   // instruction classes; R-type add/sub kept apart so EXEC can pick alu_ctr
   typedef enum logic [3:0] {
      CL_ILLEGAL = 4'd0,
      CL_ADDU    = 4'd1,
      CL_SUBU    = 4'd2,
      CL_JR      = 4'd3,
      CL_ORI     = 4'd4,
      CL_LUI     = 4'd5,
      CL_LW      = 4'd6,
      CL_SW      = 4'd7,
      CL_BEQ     = 4'd8,
      CL_J       = 4'd9,
      CL_JAL     = 4'd10
   } iclass_t;

   // classes that go through the ALU in EXEC
   function automatic logic uses_exec(input iclass_t c);
      return (c == CL_ADDU) || (c == CL_SUBU) || (c == CL_ORI) ||
             (c == CL_LUI)  || (c == CL_LW)   || (c == CL_SW);
   endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> IR/datapath signal bundle.
// Latency: n/a (wires only).
// Backpressure: memory stalls arrive as mem_ready=0.
// master: the controller (consumes opcode/func/zero/mem_ready, drives controls).
// slave : the IR/datapath/memory side.
interface mc_controller_if #(
   parameter int CNT_W = 32
);
   logic [5:0]       opcode;
   logic [5:0]       func;
   logic             zero;
   logic             mem_ready;
   logic             pc_write;
   logic [1:0]       pc_sel;
   logic             ir_write;
   logic             mem_read;
   logic             mem_write;
   logic             reg_write;
   logic [1:0]       reg_dst;
   logic [1:0]       wd_sel;
   logic             alu_src;
   logic [1:0]       ext_op;
   logic [3:0]       alu_ctr;
   logic             retire;
   logic [CNT_W-1:0] retired_count;
   logic [2:0]       state;

   modport master (
      input  opcode, func, zero, mem_ready,
      output pc_write, pc_sel, ir_write, mem_read, mem_write, reg_write,
             reg_dst, wd_sel, alu_src, ext_op, alu_ctr, retire,
             retired_count, state
   );

   modport slave (
      output opcode, func, zero, mem_ready,
      input  pc_write, pc_sel, ir_write, mem_read, mem_write, reg_write,
             reg_dst, wd_sel, alu_src, ext_op, alu_ctr, retire,
             retired_count, state
   );
endinterface

// File: rtl/mc_controller_decode.sv
// mc_decode: opcode/func -> instruction class.
// Latency: combinational, 0 cycles.
// Backpressure: none.
// Ports: i_opcode IR[31:26], i_func IR[5:0], o_class decoded class
//        (anything not recognised, including nop, is CL_ILLEGAL).
module mc_decode
   import mc_defs::*;
(
   input  logic [5:0] i_opcode,
   input  logic [5:0] i_func,
   output iclass_t    o_class
);

   always_comb begin
      o_class = CL_ILLEGAL;
      case (i_opcode)
         OP_RTYPE: begin
            case (i_func)
               FN_ADDU: o_class = CL_ADDU;
               FN_SUBU: o_class = CL_SUBU;
               FN_JR:   o_class = CL_JR;
               default: o_class = CL_ILLEGAL;
            endcase
         end
         OP_ORI:  o_class = CL_ORI;
         OP_LUI:  o_class = CL_LUI;
         OP_LW:   o_class = CL_LW;
         OP_SW:   o_class = CL_SW;
         OP_BEQ:  o_class = CL_BEQ;
         OP_J:    o_class = CL_J;
         OP_JAL:  o_class = CL_JAL;
         default: o_class = CL_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle FSM sequencing one instruction over a shared
//   ALU/memory datapath; drives all enables/selects, counts retirements.
// Latency: CPI 2..5 with mem_ready=1; outputs combinational from state.
// Backpressure: FETCH/MEM_RD/MEM_WR hold while mem_ready=0.
// Ports: clk, reset (async, active high); bus (master modport) carries
//   opcode/func/zero/mem_ready in, datapath controls, retire,
//   retired_count and debug state out.
module mc_controller
   import mc_defs::*;
#(
   parameter int CNT_W = 32
)(
   input  logic             clk,
   input  logic             reset,
   mc_controller_if.master  bus
);

   state_t           r_state;
   iclass_t          r_class;
   logic [CNT_W-1:0] r_count;

   iclass_t          w_dec_class;
   state_t           w_next;
   logic             w_pc_write;
   logic [1:0]       w_pc_sel;
   logic             w_ir_write;
   logic             w_mem_read;
   logic             w_mem_write;
   logic             w_reg_write;
   logic [1:0]       w_reg_dst;
   logic [1:0]       w_wd_sel;
   logic             w_alu_src;
   logic [1:0]       w_ext_op;
   logic [3:0]       w_alu_ctr;
   logic             w_retire;

   mc_decode u_decode (
      .i_opcode (bus.opcode),
      .i_func   (bus.func),
      .o_class  (w_dec_class)
   );

   // In DECODE the class comes straight from the IR; every later state uses
   // the copy captured on the DECODE exit edge, so IR churn is harmless.
   always_comb begin
      w_next      = r_state;
      w_pc_write  = 1'b0;
      w_pc_sel    = PC_SEQ;
      w_ir_write  = 1'b0;
      w_mem_read  = 1'b0;
      w_mem_write = 1'b0;
      w_reg_write = 1'b0;
      w_reg_dst   = RD_RT;
      w_wd_sel    = WD_ALU;
      w_alu_src   = 1'b0;
      w_ext_op    = EXT_ZERO;
      w_alu_ctr   = ALU_ADD;
      w_retire    = 1'b0;

      case (r_state)
         ST_FETCH: begin
            w_mem_read = 1'b1;
            if (bus.mem_ready) begin
               w_ir_write = 1'b1;
               w_pc_write = 1'b1;
               w_pc_sel   = PC_SEQ;
               w_next     = ST_DECODE;
            end
         end

         ST_DECODE: begin
            if (uses_exec(w_dec_class)) begin
               w_next = ST_EXEC;
            end else if (w_dec_class == CL_BEQ) begin
               w_next = ST_BRANCH;
            end else if ((w_dec_class == CL_J) || (w_dec_class == CL_JAL) ||
                         (w_dec_class == CL_JR)) begin
               w_next = ST_JUMP;
            end else begin
               // illegal encodings retire here with no architectural effect
               w_next   = ST_FETCH;
               w_retire = 1'b1;
            end
         end

         ST_EXEC: begin
            case (r_class)
               CL_ADDU: w_alu_ctr = ALU_ADD;
               CL_SUBU: w_alu_ctr = ALU_SUB;
               CL_ORI: begin
                  w_alu_src = 1'b1;
                  w_ext_op  = EXT_ZERO;
                  w_alu_ctr = ALU_OR;
               end
               CL_LUI: begin
                  // rs is $0, so OR with imm<<16 yields the upper immediate
                  w_alu_src = 1'b1;
                  w_ext_op  = EXT_HI;
                  w_alu_ctr = ALU_OR;
               end
               CL_LW, CL_SW: begin
                  w_alu_src = 1'b1;
                  w_ext_op  = EXT_SIGN;
                  w_alu_ctr = ALU_ADD;
               end
               default: ;
            endcase
            if (r_class == CL_LW)
               w_next = ST_MEM_RD;
            else if (r_class == CL_SW)
               w_next = ST_MEM_WR;
            else
               w_next = ST_WB;
         end

         ST_MEM_RD: begin
            w_mem_read = 1'b1;
            if (bus.mem_ready)
               w_next = ST_WB;
         end

         ST_MEM_WR: begin
            w_mem_write = 1'b1;
            if (bus.mem_ready) begin
               w_next   = ST_FETCH;
               w_retire = 1'b1;
            end
         end

         ST_WB: begin
            w_reg_write = 1'b1;
            w_retire    = 1'b1;
            w_next      = ST_FETCH;
            case (r_class)
               CL_ADDU, CL_SUBU: w_reg_dst = RD_RD;
               CL_LW:            w_wd_sel  = WD_MDR;
               default: ;
            endcase
         end

         ST_BRANCH: begin
            w_alu_src  = 1'b0;
            w_alu_ctr  = ALU_SUB;
            w_ext_op   = EXT_SIGN;
            w_pc_sel   = PC_BRANCH;
            w_pc_write = bus.zero;
            w_retire   = 1'b1;
            w_next     = ST_FETCH;
         end

         ST_JUMP: begin
            w_pc_write = 1'b1;
            w_retire   = 1'b1;
            w_next     = ST_FETCH;
            case (r_class)
               CL_JR:  w_pc_sel = PC_GPR;
               CL_JAL: begin
                  w_pc_sel    = PC_JUMP;
                  w_reg_write = 1'b1;
                  w_reg_dst   = RD_RA;
                  w_wd_sel    = WD_PC;
               end
               default: w_pc_sel = PC_JUMP;
            endcase
         end

         default: w_next = ST_FETCH;
      endcase

      // reset is asynchronous: quiet every control in the same cycle it rises
      if (reset) begin
         w_pc_write  = 1'b0;
         w_pc_sel    = PC_SEQ;
         w_ir_write  = 1'b0;
         w_mem_read  = 1'b0;
         w_mem_write = 1'b0;
         w_reg_write = 1'b0;
         w_reg_dst   = RD_RT;
         w_wd_sel    = WD_ALU;
         w_alu_src   = 1'b0;
         w_ext_op    = EXT_ZERO;
         w_alu_ctr   = ALU_ADD;
         w_retire    = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_FETCH;
         r_class <= CL_ILLEGAL;
         r_count <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == ST_DECODE)
            r_class <= w_dec_class;
         if (w_retire)
            r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign bus.pc_write      = w_pc_write;
   assign bus.pc_sel        = w_pc_sel;
   assign bus.ir_write      = w_ir_write;
   assign bus.mem_read      = w_mem_read;
   assign bus.mem_write     = w_mem_write;
   assign bus.reg_write     = w_reg_write;
   assign bus.reg_dst       = w_reg_dst;
   assign bus.wd_sel        = w_wd_sel;
   assign bus.alu_src       = w_alu_src;
   assign bus.ext_op        = w_ext_op;
   assign bus.alu_ctr       = w_alu_ctr;
   assign bus.retire        = w_retire;
   assign bus.retired_count = r_count;
   assign bus.state         = r_state;

endmodule

// File: doc/mc_controller.md
# mc_controller

Multi-cycle control unit for the MIPS-subset CPU. It sequences one instruction through FETCH/DECODE/EXEC/MEM/WB states over a shared datapath with one ALU and one memory port, and waits on a memory-ready handshake. It drives every datapath enable and mux select, and keeps a retired-instruction counter. It sits between the IR (opcode/func source) and the datapath, and replaces the single-cycle decoder in the multi-cycle CPU top.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- opcode  in  6  IR[31:26], stable from DECODE until the next FETCH
- func  in  6  IR[5:0]
- zero  in  1  ALU result equals zero (rs==rt compare)
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  PC <- selected next PC
- pc_sel  out  2  00 PC+4, 01 PC+(sext(imm)<<2), 10 {PC[31:28],idx,00}, 11 GPR[rs]
- ir_write  out  1  IR <- memory read data
- mem_read  out  1  memory read request (instruction or data)
- mem_write  out  1  memory write request
- reg_write  out  1  GPR write enable
- reg_dst  out  2  00 rt, 01 rd, 10 $31
- wd_sel  out  2  00 ALU result, 01 MDR, 10 PC (already PC+4)
- alu_src  out  1  0 GPR[rt], 1 extended immediate
- ext_op  out  2  00 zero-extend, 01 sign-extend, 10 imm<<16
- alu_ctr  out  4  0000 add, 0001 sub, 0010 or
- retire  out  1  one-cycle pulse when an instruction completes
- retired_count  out  CNT_W  number of instructions retired, wraps
- state  out  3  current state, for debug

## Operation
- Instruction classes decoded from opcode/func:
  - R_ALU: op 000000 with func 100001 addu or 100011 subu
  - JR: op 000000, func 001000
  - ORI 001101, LUI 001111, LW 100011, SW 101011, BEQ 000100, J 000010, JAL 000011
  - Any other encoding, including nop (all zeros), is ILLEGAL: it has no architectural effect.
- States and encodings: FETCH 0, DECODE 1, EXEC 2, MEM_RD 3, MEM_WR 4, WB 5, BRANCH 6, JUMP 7.
- FETCH:
  - mem_read=1.
  - While mem_ready=0, stay here with no other enables.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_sel=00, then go to DECODE.
- DECODE: all enables 0. Next state by class:
  - R_ALU/ORI/LUI/LW/SW → EXEC
  - BEQ → BRANCH
  - J/JAL/JR → JUMP
  - ILLEGAL → FETCH, with retire=1
- EXEC: alu_src, ext_op and alu_ctr per class:
  - R_ALU: alu_src 0, alu_ctr add or sub
  - ORI: alu_src 1, ext 00, or
  - LUI: alu_src 1, ext 10, or (rs=$0 by encoding)
  - LW/SW: alu_src 1, ext 01, add
  - Next state: LW → MEM_RD, SW → MEM_WR, otherwise WB. The ALU output register captures the result.
- MEM_RD: mem_read=1; hold until mem_ready=1, then go to WB.
- MEM_WR: mem_write=1; hold until mem_ready=1, then go to FETCH with retire=1.
- WB: reg_write=1, then go to FETCH with retire=1.
  - R_ALU: reg_dst 01, wd_sel 00
  - ORI/LUI: reg_dst 00, wd_sel 00
  - LW: reg_dst 00, wd_sel 01
- BRANCH: alu_src 0, alu_ctr sub, pc_sel 01, ext_op 01, pc_write=zero. Go to FETCH with retire=1.
- JUMP: pc_write=1, then go to FETCH with retire=1.
  - J: pc_sel 10
  - JAL: pc_sel 10, reg_write=1, reg_dst 10, wd_sel 10
  - JR: pc_sel 11
- All outputs not listed for a state are 0.
- retired_count increments on every retire and wraps from all-ones to 0.

## Timing
- Reset:
  - state=FETCH, retired_count=0.
  - While reset is high, every enable (pc_write, ir_write, mem_read, mem_write, reg_write, retire) is forced to 0. Selects are 0.
  - Reset asserted mid-instruction aborts it; no write enable may assert in the reset cycle.
- Outputs are combinational from state, decoded class, zero and mem_ready. State, the class register and the counter update on the rising edge of clk.
- Decoded class is registered at the DECODE→next edge, so opcode changes after DECODE have no effect.
- CPI with mem_ready constantly 1:
  - R_ALU/ORI/LUI 4, LW 5, SW 4, BEQ 3, J/JAL/JR 3, ILLEGAL 2
  - Each cycle of mem_ready=0 in FETCH/MEM_RD/MEM_WR adds one cycle.
- retire is asserted in the last cycle of the instruction. retired_count shows the new value one cycle later.

## Structure
- Shared package mc_defs:
  - state encodings
  - opcode/func constants
  - pc_sel, reg_dst, wd_sel, ext_op and alu_ctr codes
  - instruction-class enumeration
- One sub-module, mc_decode: combinational opcode/func → class.
- The FSM, output logic and counter live in mc_controller.

## Test plan
- Reset held 3 cycles then released, mem_ready=1:
  - enables stay 0 during reset
  - first cycle after release: state=0, mem_read=1, ir_write=1, pc_write=1
- addu sequence:
  - state trace 0,1,2,5,0
  - alu_ctr 0000 in EXEC
  - WB: reg_write=1, reg_dst=01
  - retire pulses once; retired_count 0→1
- lw with mem_ready low for 2 cycles in MEM_RD:
  - state trace 0,1,2,3,3,3,5,0 (7 cycles)
  - WB: wd_sel=01
- beq with zero=1, then with zero=0:
  - BRANCH: pc_sel=01 both times
  - pc_write=1 only in the zero=1 case
  - 3 cycles each
- jal then jr:
  - jal JUMP: pc_sel=10, reg_write=1, reg_dst=10, wd_sel=10
  - jr JUMP: pc_sel=11, reg_write=0
- Illegal opcode 111111:
  - trace 0,1,0 with retire in DECODE and no write enables
- Reset asserted during MEM_WR: mem_write drops immediately and state returns to 0.
- Counter preset near all-ones via 2^CNT_W retires (CNT_W=4): count wraps 15→0.
